// File: rtl/unidade_acesso_memoria.sv
// Load/store unit between the MEM stage and a word-addressed data memory.
// Sub-word stores use read-modify-write; misaligned accesses complete with an error pulse.
module unidade_acesso_memoria #(
    parameter int LARG_END = 28
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic [1:0]            tamanho,
    input  logic                  sinalizado,
    input  logic [LARG_END-1:0]   endereco,
    input  logic [31:0]           dado_Escrito,
    input  logic [31:0]           mem_dado_Lido,
    output logic [LARG_END-3:0]   mem_endereco,
    output logic                  mem_memWrite,
    output logic [31:0]           mem_dado_Escrito,
    output logic [31:0]           dado_Lido,
    output logic                  stall,
    output logic                  pronto,
    output logic                  erro_alinhamento
);

    // state     | meaning
    // OCIOSO    | idle, sampling requests
    // LEITURA   | memory word read (load result or RMW old word)
    // ESCRITA   | memory write strobe
    // CONCLUIDO | completion pulse, pipeline released
    localparam logic [1:0] OCIOSO    = 2'd0;
    localparam logic [1:0] LEITURA   = 2'd1;
    localparam logic [1:0] ESCRITA   = 2'd2;
    localparam logic [1:0] CONCLUIDO = 2'd3;

    logic [1:0]          estado_q, estado_d;
    logic [LARG_END-1:0] end_q, end_d;
    logic [1:0]          tam_q, tam_d;
    logic                sin_q, sin_d;
    logic                escr_q, escr_d;
    logic                desal_q, desal_d;
    logic [31:0]         dado_q, dado_d;
    logic [31:0]         palavra_q, palavra_d;
    logic [31:0]         lido_q, lido_d;

    logic        req;
    logic        desal_in;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] carga_ext;
    logic [31:0] mesclado;

    assign req      = memRead | memWrite;
    assign desal_in = (tamanho == 2'b01) ? endereco[0] :
                      (tamanho[1]        ? (endereco[1:0] != 2'b00) : 1'b0);

    always_comb begin
        byte_sel  = mem_dado_Lido[{end_q[1:0], 3'b000} +: 8];
        half_sel  = end_q[1] ? mem_dado_Lido[31:16] : mem_dado_Lido[15:0];
        carga_ext = mem_dado_Lido;
        if (tam_q == 2'b00)
            carga_ext = {{24{sin_q & byte_sel[7]}}, byte_sel};
        else if (tam_q == 2'b01)
            carga_ext = {{16{sin_q & half_sel[15]}}, half_sel};
    end

    // Only the addressed lane is replaced; the rest comes from the word read in LEITURA.
    always_comb begin
        mesclado = dado_q;
        if (tam_q == 2'b00) begin
            mesclado = palavra_q;
            mesclado[{end_q[1:0], 3'b000} +: 8] = dado_q[7:0];
        end else if (tam_q == 2'b01) begin
            mesclado = palavra_q;
            if (end_q[1])
                mesclado[31:16] = dado_q[15:0];
            else
                mesclado[15:0] = dado_q[15:0];
        end
    end

    always_comb begin
        estado_d  = estado_q;
        end_d     = end_q;
        tam_d     = tam_q;
        sin_d     = sin_q;
        escr_d    = escr_q;
        desal_d   = desal_q;
        dado_d    = dado_q;
        palavra_d = palavra_q;
        lido_d    = lido_q;
        case (estado_q)
            OCIOSO: begin
                if (req) begin
                    end_d   = endereco;
                    tam_d   = tamanho;
                    sin_d   = sinalizado;
                    dado_d  = dado_Escrito;
                    escr_d  = memWrite;
                    desal_d = desal_in;
                    if (desal_in)
                        estado_d = CONCLUIDO;
                    else if (memWrite && tamanho[1])
                        estado_d = ESCRITA;
                    else
                        estado_d = LEITURA;
                end
            end
            LEITURA: begin
                if (escr_q) begin
                    palavra_d = mem_dado_Lido;
                    estado_d  = ESCRITA;
                end else begin
                    lido_d   = carga_ext;
                    estado_d = CONCLUIDO;
                end
            end
            ESCRITA:  estado_d = CONCLUIDO;
            default:  estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= OCIOSO;
            end_q     <= '0;
            tam_q     <= '0;
            sin_q     <= 1'b0;
            escr_q    <= 1'b0;
            desal_q   <= 1'b0;
            dado_q    <= '0;
            palavra_q <= '0;
            lido_q    <= '0;
        end else begin
            estado_q  <= estado_d;
            end_q     <= end_d;
            tam_q     <= tam_d;
            sin_q     <= sin_d;
            escr_q    <= escr_d;
            desal_q   <= desal_d;
            dado_q    <= dado_d;
            palavra_q <= palavra_d;
            lido_q    <= lido_d;
        end
    end

    assign mem_endereco     = (estado_q != OCIOSO) ? end_q[LARG_END-1:2] : '0;
    assign mem_memWrite     = (estado_q == ESCRITA);
    assign mem_dado_Escrito = (estado_q == ESCRITA) ? mesclado : 32'h0;
    assign dado_Lido        = lido_q;
    assign stall            = ((estado_q == OCIOSO) & req) | (estado_q == LEITURA) | (estado_q == ESCRITA);
    assign pronto           = (estado_q == CONCLUIDO);
    assign erro_alinhamento = (estado_q == CONCLUIDO) & desal_q;

endmodule

// File: tb/tb_unidade_acesso_memoria.sv
// Directed bench for unidade_acesso_memoria with a small word memory and an expectation queue.
module tb_unidade_acesso_memoria;

    logic        clock;
    logic        reset;
    logic        memRead;
    logic        memWrite;
    logic [1:0]  tamanho;
    logic        sinalizado;
    logic [27:0] endereco;
    logic [31:0] dado_Escrito;
    logic [31:0] mem_dado_Lido;
    logic [25:0] mem_endereco;
    logic        mem_memWrite;
    logic [31:0] mem_dado_Escrito;
    logic [31:0] dado_Lido;
    logic        stall;
    logic        pronto;
    logic        erro_alinhamento;

    unidade_acesso_memoria #(.LARG_END(28)) dut (
        .clock            (clock),
        .reset            (reset),
        .memRead          (memRead),
        .memWrite         (memWrite),
        .tamanho          (tamanho),
        .sinalizado       (sinalizado),
        .endereco         (endereco),
        .dado_Escrito     (dado_Escrito),
        .mem_dado_Lido    (mem_dado_Lido),
        .mem_endereco     (mem_endereco),
        .mem_memWrite     (mem_memWrite),
        .mem_dado_Escrito (mem_dado_Escrito),
        .dado_Lido        (dado_Lido),
        .stall            (stall),
        .pronto           (pronto),
        .erro_alinhamento (erro_alinhamento)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] mem [0:63];
    always @(posedge clock)
        if (mem_memWrite)
            mem[mem_endereco[5:0]] <= mem_dado_Escrito;
    assign mem_dado_Lido = mem[mem_endereco[5:0]];

    typedef struct {
        string       tag;
        int          lat;
        logic        erro;
        logic        has_wr;
        logic [25:0] wa;
        logic [31:0] wd;
        logic [31:0] lido;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input string tag);
        memRead  = 1'b0;
        memWrite = 1'b0;
        @(negedge clock);
        chk(tag, 64'({stall, pronto, erro_alinhamento, mem_memWrite, mem_endereco, mem_dado_Escrito}), 64'h0);
    endtask

    task automatic do_op(input string tag, input logic rd, input logic wr, input logic [1:0] tam,
                         input logic sin, input logic [27:0] addr, input logic [31:0] wdata,
                         input int lat, input logic erro, input logic has_wr, input logic [31:0] wd,
                         input logic [31:0] lido, input logic b2b);
        exp_t        e;
        int          off;
        int          nwr;
        int          wr_idx;
        logic [25:0] wr_a;
        logic [31:0] wr_dat;
        logic        stall_ok;
        logic        done;
        e.tag = tag; e.lat = lat; e.erro = erro; e.has_wr = has_wr;
        e.wa = addr[27:2]; e.wd = wd; e.lido = lido;
        sb.push_back(e);
        memRead = rd; memWrite = wr; tamanho = tam; sinalizado = sin;
        endereco = addr; dado_Escrito = wdata;
        off = b2b ? 1 : 0;
        stall_ok = 1'b1;
        nwr = 0; wr_idx = 0; wr_a = '0; wr_dat = '0; done = 1'b0;
        if (!b2b) begin
            #1;
            if (stall !== 1'b1) stall_ok = 1'b0;
        end
        for (int i = 1; i <= 8 && !done; i++) begin
            @(negedge clock);
            if (mem_memWrite === 1'b1) begin
                nwr++; wr_idx = i; wr_a = mem_endereco; wr_dat = mem_dado_Escrito;
            end
            if (pronto === 1'b1) begin
                e = sb.pop_front();
                done = 1'b1;
                chk({e.tag, "/latency"}, 64'(i), 64'(e.lat + off));
                chk({e.tag, "/erro"}, 64'(erro_alinhamento), 64'(e.erro));
                chk({e.tag, "/dado_Lido"}, 64'(dado_Lido), 64'(e.lido));
                chk({e.tag, "/stall_busy"}, 64'(stall_ok), 64'd1);
                chk({e.tag, "/stall_done"}, 64'(stall), 64'd0);
                chk({e.tag, "/n_writes"}, 64'(nwr), 64'(e.has_wr));
                if (e.has_wr) begin
                    chk({e.tag, "/wr_cycle"}, 64'(wr_idx), 64'(e.lat - 1 + off));
                    chk({e.tag, "/wr_addr"}, 64'(wr_a), 64'(e.wa));
                    chk({e.tag, "/wr_data"}, 64'(wr_dat), 64'(e.wd));
                end
            end else if (stall !== 1'b1) begin
                stall_ok = 1'b0;
            end
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s/timeout: observed no pronto, expected pronto", tag);
            void'(sb.pop_front());
        end
    endtask

    int rst_wr;

    initial begin
        reset = 1'b1; memRead = 1'b0; memWrite = 1'b0; tamanho = 2'b00;
        sinalizado = 1'b0; endereco = '0; dado_Escrito = '0;
        repeat (3) @(negedge clock);
        chk("reset/ctrl", 64'({stall, pronto, erro_alinhamento, mem_memWrite}), 64'h0);
        chk("reset/addr_data", 64'({mem_endereco, mem_dado_Escrito}), 64'h0);
        chk("reset/dado_Lido", 64'(dado_Lido), 64'h0);
        reset = 1'b0;
        idle_chk("idle0");

        // word store, load back, then byte RMW on 0x11223344
        do_op("st_w",   0, 1, 2'b10, 0, 28'h10, 32'hDEADBEEF, 2, 0, 1, 32'hDEADBEEF, 32'h0, 0);
        idle_chk("idle1");
        do_op("ld_w",   1, 0, 2'b10, 0, 28'h10, 32'h0, 2, 0, 0, 32'h0, 32'hDEADBEEF, 0);
        idle_chk("idle2");
        do_op("st_w2",  0, 1, 2'b10, 0, 28'h10, 32'h11223344, 2, 0, 1, 32'h11223344, 32'hDEADBEEF, 0);
        idle_chk("idle3");
        do_op("st_b",   0, 1, 2'b00, 0, 28'h11, 32'hFFFFFFAA, 3, 0, 1, 32'h1122AA44, 32'hDEADBEEF, 0);
        idle_chk("idle4");
        do_op("ld_rmw", 1, 0, 2'b10, 0, 28'h10, 32'h0, 2, 0, 0, 32'h0, 32'h1122AA44, 0);
        idle_chk("idle5");

        // lane selection and extension on 0x80F07F85
        do_op("st_ext", 0, 1, 2'b10, 0, 28'h20, 32'h80F07F85, 2, 0, 1, 32'h80F07F85, 32'h1122AA44, 0);
        idle_chk("idle6");
        do_op("ld_sb0", 1, 0, 2'b00, 1, 28'h20, 32'h0, 2, 0, 0, 32'h0, 32'hFFFFFF85, 0);
        idle_chk("idle7");
        do_op("ld_ub0", 1, 0, 2'b00, 0, 28'h20, 32'h0, 2, 0, 0, 32'h0, 32'h00000085, 0);
        idle_chk("idle8");
        do_op("ld_sh2", 1, 0, 2'b01, 1, 28'h22, 32'h0, 2, 0, 0, 32'h0, 32'hFFFF80F0, 0);
        idle_chk("idle9");
        do_op("ld_uh2", 1, 0, 2'b01, 0, 28'h22, 32'h0, 2, 0, 0, 32'h0, 32'h000080F0, 0);
        idle_chk("idle10");
        do_op("ld_sb3", 1, 0, 2'b00, 1, 28'h23, 32'h0, 2, 0, 0, 32'h0, 32'hFFFFFF80, 0);
        idle_chk("idle11");
        do_op("st_h2",  0, 1, 2'b01, 0, 28'h22, 32'h0000BEEF, 3, 0, 1, 32'hBEEF7F85, 32'hFFFFFF80, 0);
        idle_chk("idle12");
        do_op("ld_h2w", 1, 0, 2'b10, 0, 28'h20, 32'h0, 2, 0, 0, 32'h0, 32'hBEEF7F85, 0);
        idle_chk("idle13");

        // misaligned accesses: error pulse at T+1, no write, dado_Lido held
        do_op("mis_ldw", 1, 0, 2'b10, 0, 28'h12, 32'h0, 1, 1, 0, 32'h0, 32'hBEEF7F85, 0);
        idle_chk("idle14");
        do_op("mis_sth", 0, 1, 2'b01, 0, 28'h13, 32'h00001234, 1, 1, 0, 32'h0, 32'hBEEF7F85, 0);
        idle_chk("idle15");
        do_op("ld_after_mis", 1, 0, 2'b10, 0, 28'h10, 32'h0, 2, 0, 0, 32'h0, 32'h1122AA44, 0);
        idle_chk("idle16");

        // read+write together is a store; then back-to-back and a held request
        do_op("prio",  1, 1, 2'b11, 0, 28'h30, 32'h55667788, 2, 0, 1, 32'h55667788, 32'h1122AA44, 0);
        do_op("b2b_ld", 1, 0, 2'b10, 0, 28'h30, 32'h0, 2, 0, 0, 32'h0, 32'h55667788, 1);
        do_op("held",  1, 0, 2'b00, 0, 28'h31, 32'h0, 2, 0, 0, 32'h0, 32'h00000077, 1);
        idle_chk("idle17");

        // reset in the middle of a byte RMW
        memRead = 1'b0; memWrite = 1'b1; tamanho = 2'b00; sinalizado = 1'b0;
        endereco = 28'h30; dado_Escrito = 32'h00000011;
        @(negedge clock);
        chk("rst_mid/stall_leitura", 64'({stall, mem_memWrite}), 64'h2);
        reset = 1'b1; memWrite = 1'b0;
        @(negedge clock);
        chk("rst_mid/ctrl", 64'({stall, pronto, erro_alinhamento, mem_memWrite}), 64'h0);
        chk("rst_mid/dado_Lido", 64'(dado_Lido), 64'h0);
        reset = 1'b0;
        rst_wr = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (mem_memWrite === 1'b1) rst_wr++;
        end
        chk("rst_mid/no_write", 64'(rst_wr), 64'h0);
        do_op("ld_after_rst", 1, 0, 2'b10, 0, 28'h30, 32'h0, 2, 0, 0, 32'h0, 32'h55667788, 0);
        idle_chk("idle18");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/unidade_acesso_memoria.md
Name: unidade_acesso_memoria

Overview:
- Load/store access unit directly upstream of the data memory (word-addressed, 32-bit, synchronous write on clock, combinational read).
- Converts MEM-stage byte-addressed requests (byte/halfword/word, signed/unsigned loads) into word accesses.
- Sub-word stores use read-modify-write.
- Stalls the pipeline until the access completes; flags misaligned accesses without touching memory.

Parameters:
- LARG_END, 28, byte-address width; word address to memory is LARG_END-2 = 26 bits.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- memRead  in  1  load request
- memWrite  in  1  store request (priority over memRead if both high)
- tamanho  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
- sinalizado  in  1  load: 1 sign-extend, 0 zero-extend
- endereco  in  LARG_END  byte address
- dado_Escrito  in  32  store data, sub-word in low bits
- mem_dado_Lido  in  32  word read from memory (combinational)
- mem_endereco  out  26  word address to memory = latched endereco[LARG_END-1:2]
- mem_memWrite  out  1  memory write enable
- mem_dado_Escrito  out  32  word to write
- dado_Lido  out  32  extended load result
- stall  out  1  hold pipeline
- pronto  out  1  one-cycle completion pulse
- erro_alinhamento  out  1  one-cycle pulse with pronto on misaligned access

Behaviour:
- States: OCIOSO, LEITURA, ESCRITA, CONCLUIDO.
- Reset (synchronous, any state, mid-operation included):
  - state to OCIOSO; all outputs 0; latched address/data/control 0.
  - An in-flight RMW is abandoned with no memory write.
- Request = memRead | memWrite, sampled only in OCIOSO. On acceptance (cycle T), latch endereco, tamanho, sinalizado, dado_Escrito and op type.
- Misalignment:
  - Half with endereco[0]=1, or word with endereco[1:0]!=0.
  - T+1 goes to CONCLUIDO with erro_alinhamento=1, pronto=1.
  - No mem_memWrite; dado_Lido keeps its previous value.
- Load: LEITURA at T+1.
  - Select lane from mem_dado_Lido (little-endian: offset 0 = bits 7:0; half offset 2 = bits 31:16).
  - Extend per sinalizado; register into dado_Lido.
  - CONCLUIDO at T+2. Latency 2.
- Word store: ESCRITA at T+1 with mem_memWrite=1, mem_dado_Escrito=latched data. CONCLUIDO at T+2.
- Sub-word store:
  - LEITURA at T+1 latches mem_dado_Lido.
  - ESCRITA at T+2 writes the merged word: only the addressed lane replaced by dado_Escrito[7:0] or [15:0], other lanes unchanged.
  - CONCLUIDO at T+3.
- mem_memWrite is high only in ESCRITA, exactly one cycle per store. mem_dado_Escrito is 0 outside ESCRITA.
- mem_endereco holds the latched word address from T+1 through CONCLUIDO.
- stall = (state==OCIOSO & request) | state==LEITURA | state==ESCRITA. stall is 0 in CONCLUIDO, so the pipeline advances at the end of CONCLUIDO.
- CONCLUIDO:
  - pronto=1; request inputs ignored.
  - Next state is always OCIOSO, so back-to-back requests have 1 idle cycle.
- dado_Lido holds its value until the next completed load or reset.
- Stores never modify dado_Lido.
- No request in OCIOSO: all outputs are 0 except dado_Lido (held).

Test Plan:
- Reset: assert reset mid sub-word store (in LEITURA) -> next cycle state OCIOSO, stall=0, no mem_memWrite ever pulsed, dado_Lido=0.
- Word store then load:
  - Store 0xDEADBEEF at 0x10 -> mem_memWrite pulse at T+1 with mem_endereco=4; pronto at T+2; stall high T..T+1.
  - Load word 0x10 -> dado_Lido=0xDEADBEEF at T+2.
- Byte store RMW: word 4 = 0x11223344, store byte 0xAA at 0x11 -> memory write at T+2 of 0x1122AA44; pronto at T+3.
- Sign/zero extension, memory word 0x80F0_7F85:
  - Signed byte load @+0 -> 0xFFFFFF85.
  - Unsigned byte load @+0 -> 0x00000085.
  - Signed half load @+2 -> 0xFFFF80F0.
- Misaligned: word load at 0x12 -> T+1 pronto=1, erro_alinhamento=1, no write, dado_Lido unchanged. Half store at 0x13 -> same, memory unchanged.
- Priority/back-to-back: memRead=memWrite=1 -> performed as store. Request held through CONCLUIDO -> not re-executed; a second request accepted in the following OCIOSO cycle.
